brm_rate_decoder: RTL and testbench

BRM_RATE_DECODER -- requirements
Module: brm_rate_decoder

---
 rtl/brm_pkg.sv | 15 +
 rtl/brm_win_cnt.sv | 36 +++
 rtl/brm_rate_decoder.sv | 95 +++++++++
 tb/tb_brm_rate_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/brm_pkg.sv
// Shared constants for the BRM rate decoder: default window size, result width and window terminal count.
package brm_pkg;

    localparam int WIN_BITS_DEF = 16;

    // One extra bit so a window of all-ones pulses (2^win_bits) fits without wrap.
    function automatic int rate_w(input int win_bits);
        return win_bits + 1;
    endfunction

    function automatic int unsigned win_tc(input int win_bits);
        return (32'd1 << win_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/brm_win_cnt.sv
// Enabled window counter; tc_o flags the last slot of the window (count at terminal value).
// No latency on tc_o (decoded from the registered count); no backpressure, advances on every enabled edge.
module brm_win_cnt
    import brm_pkg::*;
#(
    parameter int WIN_BITS = WIN_BITS_DEF
) (
    input  logic ck_i,
    input  logic rn_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WIN_BITS-1:0] TC = WIN_BITS'(win_tc(WIN_BITS));

    logic [WIN_BITS-1:0] wcnt_q;
    logic [WIN_BITS-1:0] wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (en_i) begin
            wcnt_d = wcnt_q + WIN_BITS'(1);
        end
    end

    always_ff @(posedge ck_i or negedge rn_i) begin
        if (!rn_i) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign tc_o = (wcnt_q == TC);

endmodule

// File: rtl/brm_rate_decoder.sv
// Counts Z_IN pulses per 2^WIN_BITS enabled cycles; result appears 1 cycle after the last sample with VALID/READY,
// a new result overwrites an unconsumed one. Optional sticky overrun flag OVR under BRM_DEC_OVERRUN_EN.
module brm_rate_decoder
    import brm_pkg::*;
#(
    parameter int WIN_BITS = WIN_BITS_DEF,
    parameter int RATE_W   = rate_w(WIN_BITS)
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              EN,
    input  logic              Z_IN,
    output logic [RATE_W-1:0] RATE,
    output logic              VALID,
    input  logic              READY,
    output logic              OVR
);

    logic              win_tc;
    logic              capture;
    logic [RATE_W-1:0] acc_q,   acc_d;
    logic [RATE_W-1:0] rate_q,  rate_d;
    logic              valid_q, valid_d;
    logic [RATE_W-1:0] acc_sum;

    brm_win_cnt #(
        .WIN_BITS (WIN_BITS)
    ) u_win_cnt (
        .ck_i (CK),
        .rn_i (RN),
        .en_i (EN),
        .tc_o (win_tc)
    );

    assign capture = EN & win_tc;
    // Include the final sample so the captured value covers the full window.
    assign acc_sum = acc_q + RATE_W'(Z_IN);

    always_comb begin
        acc_d   = acc_q;
        rate_d  = rate_q;
        valid_d = valid_q;
        if (capture) begin
            acc_d   = '0;
            rate_d  = acc_sum;
            valid_d = 1'b1;
        end else begin
            if (EN) begin
                acc_d = acc_sum;
            end
            if (valid_q && READY) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            acc_q   <= '0;
            rate_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            rate_q  <= rate_d;
            valid_q <= valid_d;
        end
    end

    assign RATE  = rate_q;
    assign VALID = valid_q;

`ifdef BRM_DEC_OVERRUN_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (capture && valid_q && !READY) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign OVR = ovr_q;
`else
    assign OVR = 1'b0;
`endif

endmodule

// File: tb/tb_brm_rate_decoder.sv
// Directed bench for brm_rate_decoder with a 16-cycle window (WIN_BITS=4).
module tb_brm_rate_decoder;

    localparam int WB = 4;
    localparam int RW = WB + 1;

`ifdef BRM_DEC_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    logic          CK = 1'b0;
    logic          RN = 1'b0;
    logic          EN = 1'b0;
    logic          Z_IN = 1'b0;
    logic          READY = 1'b0;
    logic [RW-1:0] RATE;
    logic          VALID;
    logic          OVR;

    int checks = 0;
    int errors = 0;

    brm_rate_decoder #(
        .WIN_BITS (WB),
        .RATE_W   (RW)
    ) dut (
        .CK    (CK),
        .RN    (RN),
        .EN    (EN),
        .Z_IN  (Z_IN),
        .RATE  (RATE),
        .VALID (VALID),
        .READY (READY),
        .OVR   (OVR)
    );

    always #5 CK = ~CK;

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CK);
        #1;
        RN = 1'b0; EN = 1'b0; Z_IN = 1'b0; READY = 1'b0;
        #2;
        RN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (RATE !== 5'd0 || VALID !== 1'b0 || OVR !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: RATE=%0d VALID=%b OVR=%b, required 0/0/0", RATE, VALID, OVR);
        end
        // READY while idle must not create or disturb anything.
        READY = 1'b1;
        repeat (3) step();
        READY = 1'b0;
        checks++;
        if (RATE !== 5'd0 || VALID !== 1'b0) begin
            errors++;
            $display("FAIL ready_idle: RATE=%0d VALID=%b, required 0/0", RATE, VALID);
        end
    endtask

    task automatic test_full_window();
        do_reset();
        EN = 1'b1; Z_IN = 1'b1;
        repeat (15) step();
        checks++;
        if (VALID !== 1'b0) begin
            errors++;
            $display("FAIL full_early: VALID=%b after 15 samples, required 0", VALID);
        end
        step();
        checks++;
        if (RATE !== 5'd16 || VALID !== 1'b1 || OVR !== 1'b0) begin
            errors++;
            $display("FAIL full_window: RATE=%0d VALID=%b OVR=%b, required 16/1/0", RATE, VALID, OVR);
        end
        EN = 1'b0;
    endtask

    task automatic test_alternating_consume();
        do_reset();
        EN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            Z_IN = (i % 2 == 0);
            step();
        end
        EN = 1'b0; Z_IN = 1'b0;
        checks++;
        if (RATE !== 5'd8 || VALID !== 1'b1) begin
            errors++;
            $display("FAIL alt_rate: RATE=%0d VALID=%b, required 8/1", RATE, VALID);
        end
        READY = 1'b1;
        step();
        READY = 1'b0;
        checks++;
        if (RATE !== 5'd8 || VALID !== 1'b0) begin
            errors++;
            $display("FAIL alt_consume: RATE=%0d VALID=%b, required 8/0", RATE, VALID);
        end
    endtask

    task automatic test_en_gating();
        do_reset();
        Z_IN = 1'b1;
        for (int i = 0; i < 31; i++) begin
            EN = (i % 2 == 1);
            step();
        end
        checks++;
        if (VALID !== 1'b0) begin
            errors++;
            $display("FAIL en_early: VALID=%b after 15 enabled edges, required 0", VALID);
        end
        EN = 1'b1;
        step();
        EN = 1'b0;
        checks++;
        if (RATE !== 5'd16 || VALID !== 1'b1) begin
            errors++;
            $display("FAIL en_gating: RATE=%0d VALID=%b, required 16/1", RATE, VALID);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        EN = 1'b1; Z_IN = 1'b1;
        repeat (16) step();
        checks++;
        if (RATE !== 5'd16 || VALID !== 1'b1 || OVR !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: RATE=%0d VALID=%b OVR=%b, required 16/1/0", RATE, VALID, OVR);
        end
        Z_IN = 1'b0;
        repeat (8) step();
        checks++;
        if (RATE !== 5'd16 || VALID !== 1'b1) begin
            errors++;
            $display("FAIL ovr_hold: RATE=%0d VALID=%b mid-window, required 16/1", RATE, VALID);
        end
        repeat (8) step();
        EN = 1'b0;
        checks++;
        if (RATE !== 5'd0 || VALID !== 1'b1 || OVR !== EXP_OVR) begin
            errors++;
            $display("FAIL ovr_second: RATE=%0d VALID=%b OVR=%b, required 0/1/%b", RATE, VALID, OVR, EXP_OVR);
        end
        // Sticky: consuming the result leaves OVR in place.
        READY = 1'b1;
        step();
        READY = 1'b0;
        checks++;
        if (VALID !== 1'b0 || OVR !== EXP_OVR) begin
            errors++;
            $display("FAIL ovr_sticky: VALID=%b OVR=%b, required 0/%b", VALID, OVR, EXP_OVR);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        EN = 1'b1; Z_IN = 1'b1;
        repeat (16) step();
        for (int i = 0; i < 15; i++) begin
            Z_IN = (i % 2 == 0);
            step();
        end
        checks++;
        if (RATE !== 5'd16 || VALID !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pending: RATE=%0d VALID=%b, required 16/1", RATE, VALID);
        end
        Z_IN = 1'b0; READY = 1'b1;
        step();
        EN = 1'b0; READY = 1'b0;
        checks++;
        if (RATE !== 5'd8 || VALID !== 1'b1 || OVR !== 1'b0) begin
            errors++;
            $display("FAIL b2b_capture: RATE=%0d VALID=%b OVR=%b, required 8/1/0", RATE, VALID, OVR);
        end
    endtask

    task automatic test_reset_mid_window();
        do_reset();
        EN = 1'b1; Z_IN = 1'b1;
        repeat (16) step();
        repeat (10) step();
        RN = 1'b0;
        #2;
        checks++;
        if (RATE !== 5'd0 || VALID !== 1'b0 || OVR !== 1'b0) begin
            errors++;
            $display("FAIL rn_async: RATE=%0d VALID=%b OVR=%b, required 0/0/0", RATE, VALID, OVR);
        end
        RN = 1'b1;
        repeat (15) step();
        checks++;
        if (VALID !== 1'b0) begin
            errors++;
            $display("FAIL rn_partial: VALID=%b after 15 post-reset samples, required 0", VALID);
        end
        step();
        EN = 1'b0;
        checks++;
        if (RATE !== 5'd16 || VALID !== 1'b1) begin
            errors++;
            $display("FAIL rn_recapture: RATE=%0d VALID=%b, required 16/1", RATE, VALID);
        end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_alternating_consume();
        test_en_gating();
        test_overrun();
        test_back_to_back();
        test_reset_mid_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
